// File: rtl/vram_loader.sv
// rtl/vram_loader.sv - block copy engine streaming image_rom words into the video_ram write port
//
// Purpose: on an accepted start, reads count words from image_rom starting at
// src_base (stride SRC_STEP) and writes them to video_ram starting at dst_base,
// one word per cycle while wr_allow is high.
//
// Ports:
//   clk                 single clock for the ROM read and RAM write ports
//   reset               asynchronous, active-high
//   start               one-cycle job request, only looked at while idle
//   src_base, dst_base  first ROM / RAM address of the job
//   count               number of words to copy (0 .. 2^RAM_AW)
//   wr_allow            1 = the pipeline may advance this cycle
//   rom_ad, rom_ce      ROM read address and clock enable
//   rom_data            ROM read data, ROM_LAT enabled cycles after the read
//   ram_ad, ram_data    RAM write address and data
//   ram_ce              RAM write strobe, one word per high cycle
//   busy                high from the accepted start until the job completes
//   done                one-cycle pulse after the last write
module vram_loader #(
  parameter int ROM_AW   = 12,
  parameter int RAM_AW   = 11,
  parameter int DW       = 8,
  parameter int ROM_LAT  = 1,
  parameter int SRC_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] src_base,
  input  logic [RAM_AW-1:0] dst_base,
  input  logic [RAM_AW:0]   count,
  input  logic              wr_allow,
  output logic [ROM_AW-1:0] rom_ad,
  output logic              rom_ce,
  input  logic [DW-1:0]     rom_data,
  output logic [RAM_AW-1:0] ram_ad,
  output logic [DW-1:0]     ram_data,
  output logic              ram_ce,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ROM_AW-1:0] STEP    = ROM_AW'(SRC_STEP);
  localparam logic [RAM_AW:0]   CNT_ONE = (RAM_AW+1)'(1);
  localparam logic [RAM_AW:0]   CNT_ZERO = '0;

  state_t state, state_nxt;

  logic [RAM_AW:0]    issue_left;   // reads still to be issued
  logic [RAM_AW:0]    write_left;   // writes still to be performed
  logic [ROM_LAT-1:0] vld;          // one bit per read in flight through the ROM

  logic accept;
  logic advance;
  logic issue;
  logic wr_fire;
  logic last_issue;
  logic last_write;

  // Shared qualifiers used by both the FSM and the datapath.
  always_comb begin
    accept     = (state == S_IDLE) && start;
    advance    = wr_allow && (state != S_IDLE);
    issue      = advance && (state == S_RUN);
    wr_fire    = advance && vld[ROM_LAT-1];
    last_issue = issue && (issue_left == CNT_ONE);
    last_write = wr_fire && (write_left == CNT_ONE);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A zero-length job never leaves IDLE; it only pulses done.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && (count != CNT_ZERO)) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_issue) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_write) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs. rom_ce doubles as the pipeline enable: the ROM output register
  // and the valid pipe move together, so a stall freezes both in lockstep.
  // ram_data is forced to zero outside write cycles so that every output is
  // quiet while idle or in reset.
  always_comb begin
    rom_ce   = advance;
    ram_ce   = wr_fire;
    ram_data = wr_fire ? rom_data : '0;
    busy     = (state != S_IDLE);
  end

  // Datapath: address generators, job counters, valid pipe and done pulse.
  // accept only happens in IDLE, where advance is low, so the load and the
  // update branches never compete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_ad     <= '0;
      ram_ad     <= '0;
      issue_left <= '0;
      write_left <= '0;
      vld        <= '0;
      done       <= 1'b0;
    end else begin
      done <= last_write || (accept && (count == CNT_ZERO));
      if (accept) begin
        rom_ad     <= src_base;
        ram_ad     <= dst_base;
        issue_left <= count;
        write_left <= count;
      end else begin
        if (issue) begin
          rom_ad     <= rom_ad + STEP;
          issue_left <= issue_left - CNT_ONE;
        end
        if (wr_fire) begin
          ram_ad     <= ram_ad + RAM_AW'(1);
          write_left <= write_left - CNT_ONE;
        end
        // In DRAIN the ROM is still clocked, but zeros enter the valid pipe
        // so those reads are never written.
        if (advance) begin
          vld[0] <= issue;
          for (int i = 1; i < ROM_LAT; i++) begin
            vld[i] <= vld[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_loader.sv
// tb/tb_vram_loader.sv - self-checking bench for vram_loader (two parameter sets)
module tb_vram_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [11:0] src_base = '0;
  logic [10:0] dst_base = '0;
  logic [11:0] count = '0;
  logic        wr_allow = 1'b0;

  logic [11:0] rom_ad0, rom_ad1;
  logic        rom_ce0, rom_ce1;
  logic [7:0]  rom_data0, rom_data1;
  logic [10:0] ram_ad0, ram_ad1;
  logic [7:0]  ram_data0, ram_data1;
  logic        ram_ce0, ram_ce1;
  logic        busy0, busy1;
  logic        done0, done1;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;   // which instance the current job targets

  always #5 clk = ~clk;

  vram_loader #(.ROM_AW(12), .RAM_AW(11), .DW(8), .ROM_LAT(1), .SRC_STEP(1)) u0 (
    .clk(clk), .reset(reset), .start(start0), .src_base(src_base), .dst_base(dst_base),
    .count(count), .wr_allow(wr_allow), .rom_ad(rom_ad0), .rom_ce(rom_ce0),
    .rom_data(rom_data0), .ram_ad(ram_ad0), .ram_data(ram_data0), .ram_ce(ram_ce0),
    .busy(busy0), .done(done0)
  );

  vram_loader #(.ROM_AW(12), .RAM_AW(11), .DW(8), .ROM_LAT(3), .SRC_STEP(2)) u1 (
    .clk(clk), .reset(reset), .start(start1), .src_base(src_base), .dst_base(dst_base),
    .count(count), .wr_allow(wr_allow), .rom_ad(rom_ad1), .rom_ce(rom_ce1),
    .rom_data(rom_data1), .ram_ad(ram_ad1), .ram_data(ram_data1), .ram_ce(ram_ce1),
    .busy(busy1), .done(done1)
  );

  // ROM contents: a fixed function of the address (low byte for addresses < 0x100).
  function automatic logic [7:0] rom_word(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]};
  endfunction

  // ROM models: ROM_LAT-deep read pipes that hold while rom_ce is low.
  logic [7:0] rp0 = '0;
  logic [7:0] rp1 [0:2] = '{8'h0, 8'h0, 8'h0};
  always @(posedge clk) if (rom_ce0) rp0 <= rom_word(rom_ad0);
  always @(posedge clk) if (rom_ce1) begin
    rp1[0] <= rom_word(rom_ad1);
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign rom_data0 = rp0;
  assign rom_data1 = rp1[2];

  logic [11:0] m_rom_ad;
  logic [10:0] m_ram_ad;
  logic [7:0]  m_ram_data;
  logic        m_rom_ce, m_ram_ce, m_busy, m_done;
  always_comb begin
    if (sel != 0) begin
      m_rom_ad = rom_ad1; m_rom_ce = rom_ce1; m_ram_ad = ram_ad1; m_ram_data = ram_data1;
      m_ram_ce = ram_ce1; m_busy = busy1; m_done = done1;
    end else begin
      m_rom_ad = rom_ad0; m_rom_ce = rom_ce0; m_ram_ad = ram_ad0; m_ram_data = ram_data0;
      m_ram_ce = ram_ce0; m_busy = busy0; m_done = done0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_start(input int s, input int d, input int c);
    src_base = 12'(s);
    dst_base = 11'(d);
    count    = 12'(c);
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
  endtask

  // mode 0: wr_allow always 1; 1: repeating 1,0,0,1,0; 2: random (2/3 high)
  function automatic logic allow_for(input int mode, input int c);
    if (mode == 1) return ((c - 1) % 5 == 0) || ((c - 1) % 5 == 3);
    if (mode == 2) return ($urandom_range(0, 2) != 0);
    return 1'b1;
  endfunction

  // Runs one job on instance sel. Cycle 0 is the cycle start is presented.
  // dup_at: cycle at which an extra start (alt job) is presented mid-job.
  // chain_at: cycle at which the next job (cs/cd/cc) is started; pre: this job
  // was already started by the previous call.
  task automatic run_job(input int s, input int d, input int c, input int mode,
                         input int dup_at, input int chain_at,
                         input int cs, input int cd, input int cc, input int pre);
    int lat = (sel != 0) ? 3 : 1;
    int step = (sel != 0) ? 2 : 1;
    int wcyc[$];
    logic [10:0] wad[$];
    logic [7:0] wdat[$];
    logic [11:0] radr[$];
    int done_cyc = -1, done_n = 0, viol = 0, busy_c1 = -1, busy_done = -1, rce_n = 0;
    int cyc = 0, bound = 4 * c + 40, bad, exp_done, extra;

    if (pre == 0) begin
      @(posedge clk); #1;
      wr_allow = 1'b1;
      set_start(s, d, c);
    end
    while (cyc <= bound) begin
      if (!(pre != 0 && cyc == 0)) begin
        @(negedge clk);
        if (m_ram_ce) begin
          wcyc.push_back(cyc); wad.push_back(m_ram_ad); wdat.push_back(m_ram_data);
          if (!wr_allow || !m_busy) viol++;
        end
        if (m_rom_ce) begin
          rce_n++;
          if (radr.size() < c) radr.push_back(m_rom_ad);
        end
        if (m_done) begin
          done_n++;
          if (done_cyc < 0) begin done_cyc = cyc; busy_done = int'(m_busy); end
        end
        if (cyc == 1) busy_c1 = int'(m_busy);
        if (done_n > 0) break;
      end
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      cyc++;
      wr_allow = allow_for(mode, cyc);
      if (cyc == dup_at) set_start(12'h777, 11'h111, 5);
      if (cyc == chain_at) set_start(cs, cd, cc);
    end
    if (chain_at < 0) begin
      extra = 0;
      repeat (3) begin
        @(posedge clk); #1; wr_allow = 1'b1;
        @(negedge clk);
        if (m_ram_ce || m_done || m_busy) extra++;
      end
      chk("quiet_after_done", extra, 0);
    end

    chk("write_count", wcyc.size(), c);
    bad = 0;
    for (int k = 0; k < wcyc.size() && k < c; k++) begin
      if (wad[k] != 11'((d + k) & 12'h7FF)) bad++;
      if (wdat[k] != rom_word(12'((s + k * step) & 16'hFFF))) bad++;
    end
    chk("write_pair_errors", bad, 0);
    if (c == 0) begin
      chk("rom_ce_cycles", rce_n, 0);
    end else begin
      chk("rom_reads", radr.size(), c);
      bad = 0;
      for (int k = 0; k < radr.size(); k++)
        if (radr[k] != 12'((s + k * step) & 16'hFFF)) bad++;
      chk("rom_addr_errors", bad, 0);
    end
    chk("done_pulses", done_n, 1);
    exp_done = (c == 0) ? 1 : ((wcyc.size() > 0) ? wcyc[wcyc.size()-1] + 1 : -2);
    chk("done_cycle", done_cyc, exp_done);
    chk("busy_at_done", busy_done, 0);
    chk("busy_after_start", busy_c1, (c != 0) ? 1 : 0);
    chk("ram_ce_outside_allow_busy", viol, 0);
    chk("ram_ad_end", int'(m_ram_ad), (d + c) & 12'h7FF);
    if (mode == 0 && c > 0 && wcyc.size() > 0) begin
      chk("first_write_cycle", wcyc[0], 1 + lat);
      chk("last_write_cycle", wcyc[wcyc.size()-1], c + lat);
    end
  endtask

  typedef struct {
    int inst; int src; int dst; int cnt; int mode; int dup_at;
  } vec_t;

  vec_t vecs[7];
  int n, guard, extra;

  initial begin
    vecs[0] = '{0, 12'h010, 11'h000, 4,    0, -1};   // basic copy
    vecs[1] = '{0, 12'h010, 11'h000, 4,    1, -1};   // wr_allow toggling
    vecs[2] = '{0, 12'h0AB, 11'h055, 0,    0, -1};   // zero-length job
    vecs[3] = '{1, 12'hFFC, 11'h7FE, 4,    0, -1};   // both addresses wrap
    vecs[4] = '{1, 12'h123, 11'h040, 2,    0,  2};   // start while busy ignored
    vecs[5] = '{0, 12'h5A5, 11'h3C3, 2048, 0, -1};   // whole RAM
    vecs[6] = '{1, 12'h001, 11'h7FF, 7,    1, -1};   // long latency with stalls

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_ad", int'(rom_ad0) | int'(rom_ad1), 0);
    chk("rst_ram_ad", int'(ram_ad0) | int'(ram_ad1), 0);
    chk("rst_strobes", int'({rom_ce0, rom_ce1, ram_ce0, ram_ce1}), 0);
    chk("rst_ram_data", int'(ram_data0) | int'(ram_data1), 0);
    chk("rst_busy_done", int'({busy0, busy1, done0, done1}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      sel = vecs[i].inst;
      run_job(vecs[i].src, vecs[i].dst, vecs[i].cnt, vecs[i].mode, vecs[i].dup_at,
              -1, 0, 0, 0, 0);
    end

    // Back-to-back: second start presented on the cycle done pulses.
    sel = 0;
    run_job(12'h300, 11'h020, 3, 0, -1, 5, 12'h400, 11'h500, 5, 0);
    run_job(12'h400, 11'h500, 5, 0, -1, -1, 0, 0, 0, 1);

    // Reset after the second write of a count=8 job.
    sel = 0;
    @(posedge clk); #1;
    wr_allow = 1'b1;
    set_start(12'h200, 11'h100, 8);
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0; guard = 0;
    while (n < 2 && guard < 40) begin
      @(negedge clk);
      if (ram_ce0) n++;
      guard++;
    end
    chk("rst_seq_writes_before", n, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_rom", int'(rom_ad0) | int'(rom_ce0), 0);
    chk("midrst_ram", int'(ram_ad0) | int'(ram_data0) | int'(ram_ce0), 0);
    chk("midrst_busy_done", int'({busy0, done0}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (ram_ce0 || busy0 || done0) extra++;
    end
    chk("after_rst_quiet", extra, 0);
    run_job(12'h234, 11'h0F0, 8, 0, -1, -1, 0, 0, 0, 0);

    // Randomised jobs against the reference model.
    for (int i = 0; i < 14; i++) begin
      sel = $urandom_range(0, 1);
      run_job($urandom_range(0, 4095), $urandom_range(0, 2047), $urandom_range(0, 40),
              2, -1, -1, 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
